// File: rtl/path_sweep_scheduler.sv
// Sweeps a bank of delay paths with repeated launch/capture trials and
// reports, per path, how many trials failed to propagate within one clock.
module path_sweep_scheduler #(
  parameter int NUM_PATHS = 8,
  parameter int SEL_W     = 3,
  parameter int TRIALS    = 16,
  parameter int CNT_W     = 5,
  parameter int SETTLE    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] path_sel,
  output logic             path_in,
  input  logic             path_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_path,
  output logic [CNT_W-1:0] res_errors
);

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESET = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q,  state_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic [CNT_W-1:0] trial_q,  trial_d;
  logic [CNT_W-1:0] err_q,    err_d;
  logic [ST_W-1:0]  settle_q, settle_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    trial_d  = trial_q;
    err_d    = err_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PRESET;
          sel_d    = '0;
          trial_d  = '0;
          err_d    = '0;
          settle_d = '0;
        end
      end
      S_PRESET: begin
        if (settle_q == ST_W'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = S_LAUNCH;
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end
      S_LAUNCH: begin
        // path_out is captured raw: a 0 here means the edge did not arrive in time
        if (!path_out) err_d = err_q + CNT_W'(1);
        if (trial_q == CNT_W'(TRIALS - 1)) begin
          state_d = S_REPORT;
        end else begin
          trial_d = trial_q + CNT_W'(1);
          state_d = S_PRESET;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          if (sel_q == SEL_W'(NUM_PATHS - 1)) begin
            state_d = S_DONE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            trial_d = '0;
            err_d   = '0;
            state_d = S_PRESET;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      sel_d    = '0;
      trial_d  = '0;
      err_d    = '0;
      settle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      trial_q  <= '0;
      err_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      trial_q  <= trial_d;
      err_q    <= err_d;
      settle_q <= settle_d;
    end
  end

  // Outputs are pure state/register decode; nothing flows through from inputs.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign path_in    = (state_q == S_LAUNCH);
  assign res_valid  = (state_q == S_REPORT);
  assign path_sel   = sel_q;
  assign res_path   = sel_q;
  assign res_errors = err_q;

endmodule

// File: tb/tb_path_sweep_scheduler.sv
// Bench for path_sweep_scheduler: cycle-position model of the sweep, randomized
// path failures and backpressure, plus literal expectations for each scenario.
module tb_path_sweep_scheduler;

  localparam int N  = 8;
  localparam int T  = 16;
  localparam int S  = 2;
  localparam int TS = T * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       res_ready = 1'b1;
  logic       busy, done, path_in, path_out, res_valid;
  logic [2:0] path_sel, res_path;
  logic [4:0] res_errors;

  path_sweep_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .path_sel(path_sel), .path_in(path_in),
    .path_out(path_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_path(res_path), .res_errors(res_errors)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Failure pattern: fm[path][trial]=1 means that trial's launch never arrives.
  logic fm [N][T];
  int   tr_idx;

  // Model: position within the current path (trials then report), plain arithmetic.
  int cyc = 0, m_pos = 0, m_err = 0, m_sel = 0;
  bit m_active = 0, m_done = 0, fv_seen = 0;
  int start_cyc = 0, done_cyc = 0, fv_cyc = 0;
  bit s_start = 0, s_abort = 0, s_ready = 0, s_pout = 0;

  assign tr_idx   = (m_pos < TS) ? m_pos / (S + 1) : 0;
  assign path_out = path_in && !fm[path_sel][tr_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_sel = 0; m_pos = 0; m_err = 0;
    end else begin
      cyc++;
      if (s_abort) begin
        m_active = 0; m_done = 0; m_sel = 0; m_pos = 0; m_err = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (s_start) begin
          m_active = 1; m_sel = 0; m_pos = 0; m_err = 0;
          start_cyc = cyc; fv_seen = 0;
        end
      end else if (m_pos < TS) begin
        if (m_pos % (S + 1) == S && !s_pout) m_err++;
        m_pos++;
        if (m_pos == TS && !fv_seen) begin fv_seen = 1; fv_cyc = cyc; end
      end else if (s_ready) begin
        if (m_sel == N - 1) begin
          m_active = 0; m_done = 1; done_cyc = cyc;
        end else begin
          m_sel++; m_pos = 0; m_err = 0;
        end
      end
    end
  end

  int log_path[$], log_err[$], log_len[$];
  int vrun = 0, done_cnt = 0;

  always @(negedge clk) begin
    s_start = start; s_abort = abort; s_ready = res_ready; s_pout = path_out;
    chk("busy", busy, int'(m_active || m_done));
    chk("done", done, int'(m_done));
    chk("path_in", path_in, int'(m_active && m_pos < TS && m_pos % (S + 1) == S));
    chk("res_valid", res_valid, int'(m_active && m_pos == TS));
    chk("path_sel", path_sel, m_sel);
    chk("res_path", res_path, m_sel);
    if (m_active && m_pos == TS) chk("res_errors", res_errors, m_err);
    if (res_valid) vrun++;
    if (res_valid && res_ready && !abort) begin
      log_path.push_back(int'(res_path));
      log_err.push_back(int'(res_errors));
      log_len.push_back(vrun);
      vrun = 0;
    end
    if (done) done_cnt++;
  end

  bit rdy_rand = 0, bp2 = 0, busy_starts = 0;
  int abort_path = -1;

  task automatic clear_fm();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < T; j++) fm[i][j] = 1'b0;
  endtask

  task automatic run_sweep(input int budget);
    int n; int bp; bit s1; bit s2; bit ab;
    n = 0; bp = 0; s1 = 0; s2 = 0; ab = 0;
    log_path.delete(); log_err.delete(); log_len.delete();
    done_cnt = 0; vrun = 0;
    start = 1'b1;
    @(posedge clk); #1;
    while ((m_active || m_done) && n < budget) begin
      res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bp2 && m_active && m_pos == TS && m_sel == 2 && bp < 5) begin
        res_ready = 1'b0; bp++;
      end
      start = 1'b0;
      if (busy_starts && !s1 && m_active && m_pos < TS && m_pos % (S + 1) == S) begin
        start = 1'b1; s1 = 1;
      end else if (busy_starts && !s2 && m_active && m_pos == TS) begin
        start = 1'b1; s2 = 1;
      end
      abort = 1'b0;
      if (abort_path >= 0 && !ab && m_active && m_sel == abort_path && m_pos / (S + 1) == 2) begin
        abort = 1'b1; ab = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    chk("sweep_in_budget", int'(n < budget), 1);
  endtask

  task automatic check_clean_sweep(input string tag);
    chk({tag, "_results"}, log_path.size(), N);
    for (int i = 0; i < N && i < log_path.size(); i++) begin
      chk({tag, "_path"}, log_path[i], i);
      chk({tag, "_errs"}, log_err[i], 0);
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int n; int pc[N];
    clear_fm();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_path_in", path_in, 0);
    chk("rst_path_sel", path_sel, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_errors", res_errors, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ideal paths
    run_sweep(2000);
    check_clean_sweep("ideal");
    chk("ideal_first_valid_lat", fv_cyc - start_cyc, 48);
    chk("ideal_done_lat", done_cyc - start_cyc, 392);

    // Dead path 5
    for (int j = 0; j < T; j++) fm[5][j] = 1'b1;
    run_sweep(2000);
    chk("dead_results", log_path.size(), N);
    for (int i = 0; i < N && i < log_err.size(); i++)
      chk("dead_errs", log_err[i], (i == 5) ? 16 : 0);
    clear_fm();

    // Alternating failures on path 2 with backpressure
    for (int j = 1; j < T; j += 2) fm[2][j] = 1'b1;
    bp2 = 1;
    run_sweep(2000);
    bp2 = 0;
    chk("alt_results", log_path.size(), N);
    if (log_path.size() > 2) begin
      chk("alt_path", log_path[2], 2);
      chk("alt_errs", log_err[2], 8);
      chk("alt_valid_cycles", log_len[2], 6);
    end
    clear_fm();

    // Abort during the third trial of path 4
    abort_path = 4;
    run_sweep(2000);
    abort_path = -1;
    chk("abort_busy", busy, 0);
    chk("abort_path_in", path_in, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_results", log_path.size(), 4);
    chk("abort_no_done", done_cnt, 0);
    run_sweep(2000);
    check_clean_sweep("post_abort");

    // Reset during path 1 PRESET
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(m_active && m_sel == 1 && m_pos < TS && m_pos % (S + 1) < S) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_path1_preset", int'(n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_path_sel", path_sel, 0);
    chk("midrst_path_in", path_in, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_errors", res_errors, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Start pulses while busy
    busy_starts = 1;
    run_sweep(2000);
    busy_starts = 0;
    check_clean_sweep("busy_start");
    chk("busy_start_first_valid_lat", fv_cyc - start_cyc, 48);
    chk("busy_start_done_lat", done_cyc - start_cyc, 392);

    // Random failures, random backpressure, stray starts
    for (int i = 0; i < N; i++) begin
      pc[i] = 0;
      for (int j = 0; j < T; j++) begin
        fm[i][j] = 1'($urandom_range(0, 1));
        pc[i] += int'(fm[i][j]);
      end
    end
    rdy_rand = 1; busy_starts = 1;
    run_sweep(4000);
    rdy_rand = 0; busy_starts = 0;
    chk("rand_results", log_path.size(), N);
    for (int i = 0; i < N && i < log_err.size(); i++) begin
      chk("rand_path", log_path[i], i);
      chk("rand_errs", log_err[i], pc[i]);
    end
    chk("rand_done_pulses", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
